wb_buffer_param: RTL and testbench
==================================

# wb_buffer_param

Parametrised write-back (store) buffer between the memory-stage pipeline latch and the cache/memory write port. It is the DEPTH-entry successor of the fixed 4-entry buffer and holds stores in program order. Entries stay speculative until their instruction's last micro-op commits, and the buffer drains committed entries from the head. It adds a squash of uncommitted entries, occupancy and almost-full reporting, and combinational store-to-load forwarding for the load pipe.

## Interface
- DEPTH, 8, number of entries; power of two, 2..32
- AW, 15, address width
- DW, 32, data width; must be 32 (byte-lane forwarding is defined on 4 bytes)
- EW, 32, EIP width
- AF_THRESH, DEPTH-2, `o_almost_full` asserts when count >= AF_THRESH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- enqueue  in  1  write a new entry at the tail
- i_vld  in  1  committed-at-enqueue flag for the new entry
- i_cachable  in  1  cacheable attribute
- i_eip  in  EW  instruction EIP of the store
- i_addr  in  AW  byte address
- i_data  in  DW  store data, right-aligned
- i_size  in  3  byte count: 1, 2 or 4; other values illegal
- commit  in  1  commit all allocated entries whose eip equals `i_eip_cmp`
- i_eip_cmp  in  EW  EIP being committed
- flush  in  1  discard every uncommitted entry
- read  in  1  cache/memory accepts the head entry
- lk_vld  in  1  load lookup request
- lk_addr  in  AW  load byte address
- lk_size  in  3  load byte count: 1, 2 or 4
- o_en_vld  out  1  head is allocated and committed; `read` only takes effect when this is 1
- o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable  out  AW/DW/EW/3/1  head entry fields
- o_alloc  out  DEPTH  per-entry allocated bitmap
- o_count  out  $clog2(DEPTH)+1  number of allocated entries
- empty, full, o_almost_full  out  1  occupancy flags
- o_overflow  out  1  one-cycle pulse when an enqueue is dropped because the buffer is full
- lk_hit  out  1  load fully covered by the youngest overlapping entry
- lk_conflict  out  1  youngest overlapping entry only partially covers the load
- lk_data  out  DW  forwarded data, right-aligned, zero-extended

## Operation
- Storage is circular. `rdptr` and `wrptr` are each $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. `count` is tracked separately; full is count==DEPTH.
- Each entry holds alloc, vld, cac, eip, addr, data and size.
- Enqueue when not full:
  - Write the entry at `wrptr`, set alloc, and set vld to `i_vld`.
  - Increment `wrptr`.
- Enqueue when full: the entry is not written, state is unchanged, and `o_overflow` pulses. The full check uses the count at the start of the cycle; a read in the same cycle does not free space.
- Commit sets vld on every allocated entry whose eip equals `i_eip_cmp`. If an entry is enqueued in the same cycle with `i_eip` equal to `i_eip_cmp`, the new entry is also committed.
- Read when `o_en_vld` is 1 clears alloc and vld at `rdptr` and increments `rdptr`. Read when `o_en_vld` is 0 is ignored.
- Flush:
  - Clears alloc on all entries where vld is 0.
  - Sets `wrptr` to `rdptr` + (number of surviving committed entries), after any same-cycle read.
  - Committed entries are always a contiguous prefix from the head; the pipeline guarantees in-order commit, and this is not checked.
- Same-cycle priority: commit is applied before flush, so entries committed this cycle survive. Flush drops a same-cycle enqueue. Enqueue and read in the same cycle give count unchanged.
- Forwarding lookup is combinational over allocated entries:
  - Overlap: byte ranges [addr, addr+size) intersect, computed at AW+1 bits with no wrap.
  - The youngest overlapping entry is the one closest to the tail going backwards from `wrptr`-1.
  - Cover: e.addr <= lk_addr and lk_addr+lk_size <= e.addr+e.size. If covered, lk_hit=1 and lk_data = (e.data >> 8*(lk_addr-e.addr)) masked to lk_size bytes.
  - If the youngest overlapping entry does not cover the load, lk_conflict=1 and lk_hit=0.
  - No overlap, or lk_vld=0, gives lk_hit=lk_conflict=0 and lk_data=0.
  - Committed and uncommitted entries both forward.

## Timing
- Reset (rst==0 at a rising edge): all alloc and vld bits 0, rdptr=wrptr=0, count=0. Outputs after reset: empty=1, full=0, o_almost_full=0, o_en_vld=0, o_alloc=0, o_overflow=0, o_count=0. Data fields are zeroed.
- Reset has priority over every other input in the same cycle and aborts any operation in flight.
- Enqueue, commit, read and flush take effect at the rising edge and are visible on the outputs in the next cycle. Enqueue-to-head latency on an empty buffer with i_vld=1 is 1 cycle.
- Head outputs, flags and lookup outputs are combinational from registered state and the lk_* inputs. Forwarding does not see an entry being enqueued in the same cycle.
- `o_overflow` is registered: it is 1 for exactly the cycle after the dropped enqueue.

## Test plan
- Reset, then enqueue DEPTH=8 entries with i_vld=1 and addr 0x10..0x17 -> full=1, o_count=8. A 9th enqueue -> o_overflow=1 for one cycle and entry 0 is unchanged.
- Enqueue 3 entries with eip 0x100 and i_vld=0 -> o_en_vld=0 and read has no effect. Commit with i_eip_cmp=0x100 -> next cycle o_en_vld=1. Three reads drain the buffer to empty=1.
- Wrap-around: 12 enqueue/read pairs with DEPTH=8 -> data exits in order, and rdptr/wrptr wrap through 7->0.
- Enqueue A and B committed, then C and D uncommitted, then flush -> o_count=2 and o_alloc shows only A and B. The next enqueue lands at the slot after B.
- Forwarding: entry {addr 0x20, size 4, data 0xDDCCBBAA}. Lookup {0x21, 2} -> lk_hit=1, lk_data=0x0000CCBB. Lookup {0x22, 4} -> lk_conflict=1. A younger entry {0x21, 1, 0xEE} followed by lookup {0x21, 1} -> lk_data=0xEE.
- Same-cycle commit and flush on eip 0x200 -> the 0x200 entries survive. Enqueue+flush in one cycle -> the enqueue is dropped.

Source files
------------

// File: rtl/wb_buffer_param.sv
// Parametrised in-order store buffer with commit, squash of uncommitted entries,
// occupancy flags and combinational store-to-load forwarding.
module wb_buffer_param #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 32,
  parameter int unsigned EW        = 32,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enqueue,
  input  logic                       i_vld,
  input  logic                       i_cachable,
  input  logic [EW-1:0]              i_eip,
  input  logic [AW-1:0]              i_addr,
  input  logic [DW-1:0]              i_data,
  input  logic [2:0]                 i_size,
  input  logic                       commit,
  input  logic [EW-1:0]              i_eip_cmp,
  input  logic                       flush,
  input  logic                       read,
  input  logic                       lk_vld,
  input  logic [AW-1:0]              lk_addr,
  input  logic [2:0]                 lk_size,
  output logic                       o_en_vld,
  output logic [AW-1:0]              o_en_addr,
  output logic [DW-1:0]              o_en_data,
  output logic [EW-1:0]              o_en_eip,
  output logic [2:0]                 o_en_size,
  output logic                       o_cachable,
  output logic [DEPTH-1:0]           o_alloc,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       empty,
  output logic                       full,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  output logic                       lk_hit,
  output logic                       lk_conflict,
  output logic [DW-1:0]              lk_data
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AW1 = AW + 1;

  logic [DEPTH-1:0]          alloc_q, alloc_d, vld_q, vld_d, cac_q, cac_d;
  logic [DEPTH-1:0][EW-1:0]  eip_q, eip_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0]  data_q, data_d;
  logic [DEPTH-1:0][2:0]     size_q, size_d;
  logic [PW-1:0]             rdptr_q, rdptr_d, wrptr_q, wrptr_d;
  logic [CW-1:0]             count_q, count_d, survivors;
  logic                      overflow_q;
  logic                      enq_w, rd_ok;

  function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign o_almost_full = (count_q >= CW'(AF_THRESH));
  assign o_count       = count_q;
  assign o_alloc       = alloc_q;
  assign o_overflow    = overflow_q;
  assign o_en_vld      = alloc_q[rdptr_q] & vld_q[rdptr_q];
  assign o_en_addr     = addr_q[rdptr_q];
  assign o_en_data     = data_q[rdptr_q];
  assign o_en_eip      = eip_q[rdptr_q];
  assign o_en_size     = size_q[rdptr_q];
  assign o_cachable    = cac_q[rdptr_q];

  assign enq_w = enqueue & ~full & ~flush;
  assign rd_ok = read & o_en_vld;

  always_comb begin
    alloc_d   = alloc_q;
    vld_d     = vld_q;
    cac_d     = cac_q;
    eip_d     = eip_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    rdptr_d   = rdptr_q;
    wrptr_d   = wrptr_q;
    survivors = '0;
    if (commit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_q[i] && eip_q[i] == i_eip_cmp) vld_d[i] = 1'b1;
      end
    end
    if (enq_w) begin
      alloc_d[wrptr_q] = 1'b1;
      vld_d[wrptr_q]   = i_vld | (commit & (i_eip == i_eip_cmp));
      cac_d[wrptr_q]   = i_cachable;
      eip_d[wrptr_q]   = i_eip;
      addr_d[wrptr_q]  = i_addr;
      data_d[wrptr_q]  = i_data;
      size_d[wrptr_q]  = i_size;
      wrptr_d          = wrptr_q + PW'(1);
    end
    if (rd_ok) begin
      alloc_d[rdptr_q] = 1'b0;
      vld_d[rdptr_q]   = 1'b0;
      rdptr_d          = rdptr_q + PW'(1);
    end
    if (flush) begin
      // Committed entries form a contiguous prefix from the head, so the tail
      // lands right after the last survivor.
      alloc_d   = alloc_d & vld_d;
      survivors = popcnt(alloc_d);
      wrptr_d   = rdptr_d + survivors[PW-1:0];
      count_d   = survivors;
    end else begin
      count_d   = count_q + CW'(enq_w) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_q    <= '0;
      vld_q      <= '0;
      cac_q      <= '0;
      eip_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      rdptr_q    <= '0;
      wrptr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      vld_q      <= vld_d;
      cac_q      <= cac_d;
      eip_q      <= eip_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      rdptr_q    <= rdptr_d;
      wrptr_q    <= wrptr_d;
      count_q    <= count_d;
      overflow_q <= enqueue & full;
    end
  end

  // Forwarding: byte ranges compared one bit wider than the address so they never wrap.
  logic [DEPTH-1:0] ovl, cov;
  logic [AW1-1:0]   l_lo, l_hi, e_lo, e_hi, off;
  logic [PW-1:0]    idx, sel;
  logic             found;
  logic [DW-1:0]    mask;

  always_comb begin
    l_lo = {1'b0, lk_addr};
    l_hi = l_lo + AW1'(lk_size);
    e_lo = '0;
    e_hi = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e_lo   = {1'b0, addr_q[i]};
      e_hi   = e_lo + AW1'(size_q[i]);
      ovl[i] = alloc_q[i] && (e_lo < l_hi) && (l_lo < e_hi);
      cov[i] = (e_lo <= l_lo) && (l_hi <= e_hi);
    end
    // Walk oldest to youngest so the youngest overlap wins.
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wrptr_q - PW'(k);
      if (ovl[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    off = l_lo - {1'b0, addr_q[sel]};
    unique case (lk_size)
      3'd1:    mask = DW'(32'h0000_00ff);
      3'd2:    mask = DW'(32'h0000_ffff);
      default: mask = '1;
    endcase
    lk_hit      = lk_vld & found & cov[sel];
    lk_conflict = lk_vld & found & ~cov[sel];
    lk_data     = lk_hit ? ((data_q[sel] >> {off[1:0], 3'b000}) & mask) : '0;
  end
endmodule

// File: tb/tb_wb_buffer_param.sv
// Scenario bench for wb_buffer_param: expected head entries queue on enqueue and are
// compared as they leave the head.
module tb_wb_buffer_param;
  logic        clk = 1'b0;
  logic        rst, enqueue, i_vld, i_cachable, commit, flush, read, lk_vld;
  logic [31:0] i_eip, i_eip_cmp, i_data;
  logic [14:0] i_addr, lk_addr;
  logic [2:0]  i_size, lk_size;
  logic        o_en_vld, o_cachable, empty, full, o_almost_full, o_overflow;
  logic        lk_hit, lk_conflict;
  logic [14:0] o_en_addr;
  logic [31:0] o_en_data, o_en_eip, lk_data;
  logic [2:0]  o_en_size;
  logic [7:0]  o_alloc;
  logic [3:0]  o_count;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic [31:0] eip;
    logic [2:0]  size;
    logic        cac;
  } ent_t;

  ent_t        sb[$];
  ent_t        exp;
  logic [82:0] got;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_buffer_param dut (
    .clk(clk), .rst(rst), .enqueue(enqueue), .i_vld(i_vld), .i_cachable(i_cachable),
    .i_eip(i_eip), .i_addr(i_addr), .i_data(i_data), .i_size(i_size), .commit(commit),
    .i_eip_cmp(i_eip_cmp), .flush(flush), .read(read), .lk_vld(lk_vld), .lk_addr(lk_addr),
    .lk_size(lk_size), .o_en_vld(o_en_vld), .o_en_addr(o_en_addr), .o_en_data(o_en_data),
    .o_en_eip(o_en_eip), .o_en_size(o_en_size), .o_cachable(o_cachable), .o_alloc(o_alloc),
    .o_count(o_count), .empty(empty), .full(full), .o_almost_full(o_almost_full),
    .o_overflow(o_overflow), .lk_hit(lk_hit), .lk_conflict(lk_conflict), .lk_data(lk_data)
  );

  task automatic clr();
    enqueue = 0; commit = 0; flush = 0; read = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    clr();
    rst = 0;
    tick();
    rst = 1;
  endtask

  // Drives enqueue fields for the next edge; optionally queues it as an expected head.
  task automatic set_enq(input logic v, input logic [31:0] eip, input logic [14:0] addr,
                         input logic [31:0] data, input logic [2:0] size, input logic push);
    ent_t e;
    e = '{addr: addr, data: data, eip: eip, size: size, cac: 1'($urandom)};
    enqueue = 1; i_vld = v; i_eip = eip; i_addr = addr; i_data = data; i_size = size;
    i_cachable = e.cac;
    if (push) sb.push_back(e);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty, full, o_almost_full, o_en_vld, o_overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=10000",
               {empty, full, o_almost_full, o_en_vld, o_overflow});
    end
    checks++;
    if ({o_alloc, o_count} !== 12'h000) begin
      errors++; $display("FAIL reset_alloc_count got=%h exp=000", {o_alloc, o_count});
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_enq(1, 32'h300 + i, 15'h10 + 15'(i), $urandom, 3'd4, 1);
      tick();
    end
    checks++;
    if ({full, o_almost_full, o_count} !== {2'b11, 4'd8}) begin
      errors++; $display("FAIL fill_full got=%b%b cnt=%0d exp=11 cnt=8", full, o_almost_full, o_count);
    end
    set_enq(1, 32'h999, 15'h7ff, 32'hdeadbeef, 3'd1, 0);
    tick();
    checks++;
    if (o_overflow !== 1'b1 || o_count !== 4'd8) begin
      errors++; $display("FAIL overflow_pulse got=%b cnt=%0d exp=1 cnt=8", o_overflow, o_count);
    end
    tick();
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear got=%b exp=0", o_overflow);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
      checks++;
      if (got !== exp || o_en_vld !== 1'b1) begin
        errors++; $display("FAIL fill_head got=%h vld=%b exp=%h", got, o_en_vld, exp);
      end
      read = 1;
      tick();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL fill_drain_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_enq(0, 32'h100, 15'h50 + 15'(i), $urandom, 3'd2, 1);
      tick();
    end
    checks++;
    if (o_en_vld !== 1'b0) begin
      errors++; $display("FAIL commit_pending_vld got=%b exp=0", o_en_vld);
    end
    read = 1;
    tick();
    checks++;
    if (o_count !== 4'd3) begin
      errors++; $display("FAIL commit_ignored_read got=%0d exp=3", o_count);
    end
    commit = 1; i_eip_cmp = 32'h100;
    tick();
    checks++;
    if (o_en_vld !== 1'b1) begin
      errors++; $display("FAIL commit_vld got=%b exp=1", o_en_vld);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL commit_head got=%h exp=%h", got, exp);
      end
      read = 1;
      tick();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL commit_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_enq(1, 32'h500, 15'h100, $urandom, 3'd4, 1);
    tick();
    for (int i = 1; i <= 12; i++) begin
      exp = sb.pop_front();
      got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, got, exp);
      end
      set_enq(1, 32'h500 + i, 15'h100 + 15'(i), $urandom, 3'd4, 1);
      read = 1;
      tick();
      checks++;
      if (o_count !== 4'd1) begin
        errors++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, o_count);
      end
    end
    exp = sb.pop_front();
    got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL wrap_last got=%h exp=%h", got, exp);
    end
    read = 1;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_enq(1, 32'h10, 15'h40, $urandom, 3'd4, 1); tick();
    set_enq(1, 32'h10, 15'h41, $urandom, 3'd4, 1); tick();
    set_enq(0, 32'h20, 15'h42, $urandom, 3'd4, 0); tick();
    set_enq(0, 32'h20, 15'h43, $urandom, 3'd4, 0); tick();
    flush = 1;
    tick();
    checks++;
    if (o_count !== 4'd2 || o_alloc !== 8'h03) begin
      errors++; $display("FAIL flush_state got cnt=%0d alloc=%h exp cnt=2 alloc=03", o_count, o_alloc);
    end
    set_enq(1, 32'h30, 15'h44, $urandom, 3'd1, 1);
    tick();
    checks++;
    if (o_alloc !== 8'h07) begin
      errors++; $display("FAIL flush_next_slot got=%h exp=07", o_alloc);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL flush_head got=%h exp=%h", got, exp);
      end
      read = 1;
      tick();
    end
  endtask

  task automatic test_forward();
    do_reset();
    set_enq(1, 32'h1, 15'h20, 32'hddccbbaa, 3'd4, 0);
    tick();
    lk_vld = 1; lk_addr = 15'h21; lk_size = 3'd2;
    #1;
    checks++;
    if ({lk_hit, lk_conflict, lk_data} !== {2'b10, 32'h0000ccbb}) begin
      errors++; $display("FAIL fwd_partial got=%b%b %h exp=10 0000ccbb", lk_hit, lk_conflict, lk_data);
    end
    lk_addr = 15'h22; lk_size = 3'd4;
    #1;
    checks++;
    if ({lk_hit, lk_conflict} !== 2'b01) begin
      errors++; $display("FAIL fwd_conflict got=%b%b exp=01", lk_hit, lk_conflict);
    end
    lk_addr = 15'h40; lk_size = 3'd1;
    #1;
    checks++;
    if ({lk_hit, lk_conflict, lk_data} !== 34'h0) begin
      errors++; $display("FAIL fwd_miss got=%b%b %h exp=00 0", lk_hit, lk_conflict, lk_data);
    end
    lk_vld = 0; lk_addr = 15'h20; lk_size = 3'd4;
    #1;
    checks++;
    if ({lk_hit, lk_conflict, lk_data} !== 34'h0) begin
      errors++; $display("FAIL fwd_novld got=%b%b %h exp=00 0", lk_hit, lk_conflict, lk_data);
    end
    lk_vld = 1;
    set_enq(0, 32'h2, 15'h21, 32'h000000ee, 3'd1, 0);
    tick();
    lk_addr = 15'h21; lk_size = 3'd1;
    #1;
    checks++;
    if ({lk_hit, lk_data} !== {1'b1, 32'hee}) begin
      errors++; $display("FAIL fwd_younger got=%b %h exp=1 000000ee", lk_hit, lk_data);
    end
    lk_addr = 15'h20;
    #1;
    checks++;
    if ({lk_hit, lk_data} !== {1'b1, 32'haa}) begin
      errors++; $display("FAIL fwd_older got=%b %h exp=1 000000aa", lk_hit, lk_data);
    end
    lk_size = 3'd2;
    #1;
    checks++;
    if ({lk_hit, lk_conflict} !== 2'b01) begin
      errors++; $display("FAIL fwd_young_partial got=%b%b exp=01", lk_hit, lk_conflict);
    end
    lk_addr = 15'h30; lk_size = 3'd1;
    set_enq(1, 32'h3, 15'h30, 32'h55, 3'd1, 0);
    #1;
    checks++;
    if (lk_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_same_cycle got=%b exp=0", lk_hit);
    end
    tick();
    checks++;
    if ({lk_hit, lk_data} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL fwd_after_enq got=%b %h exp=1 00000055", lk_hit, lk_data);
    end
    lk_vld = 0;
  endtask

  task automatic test_commit_flush();
    do_reset();
    set_enq(0, 32'h200, 15'h60, $urandom, 3'd4, 1); tick();
    set_enq(0, 32'h200, 15'h61, $urandom, 3'd4, 1); tick();
    set_enq(0, 32'h300, 15'h62, $urandom, 3'd4, 0); tick();
    commit = 1; i_eip_cmp = 32'h200; flush = 1;
    tick();
    checks++;
    if (o_count !== 4'd2 || o_alloc !== 8'h03 || o_en_vld !== 1'b1) begin
      errors++;
      $display("FAIL cf_survive got cnt=%0d alloc=%h vld=%b exp cnt=2 alloc=03 vld=1",
               o_count, o_alloc, o_en_vld);
    end
    set_enq(1, 32'h350, 15'h63, $urandom, 3'd4, 0);
    flush = 1;
    tick();
    checks++;
    if (o_count !== 4'd2 || o_alloc !== 8'h03) begin
      errors++; $display("FAIL cf_enq_dropped got cnt=%0d alloc=%h exp cnt=2 alloc=03", o_count, o_alloc);
    end
    set_enq(0, 32'h400, 15'h64, $urandom, 3'd2, 1);
    commit = 1; i_eip_cmp = 32'h400;
    tick();
    flush = 1;
    tick();
    checks++;
    if (o_count !== 4'd3) begin
      errors++; $display("FAIL cf_enq_commit got cnt=%0d exp=3", o_count);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {o_en_addr, o_en_data, o_en_eip, o_en_size, o_cachable};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL cf_head got=%h exp=%h", got, exp);
      end
      read = 1;
      tick();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL cf_empty got=%b exp=1", empty);
    end
  endtask

  initial begin
    rst = 0; lk_vld = 0; lk_addr = '0; lk_size = 3'd1;
    i_vld = 0; i_cachable = 0; i_eip = '0; i_addr = '0; i_data = '0; i_size = 3'd1;
    i_eip_cmp = '0;
    clr();
    test_reset();
    test_fill_overflow();
    test_commit();
    test_wrap();
    test_flush();
    test_forward();
    test_commit_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
